// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer: streams a halted-CPU snapshot (PC, cycle counter, register file,
// leading data-memory words) to a UART byte transmitter, MSB-first, one byte per handshake.
module debug_dump_sequencer #(
    parameter int OUTPUT_WORD_LENGTH    = 8,
    parameter int LONGITUD_DATO         = 32,
    parameter int CANT_REGISTROS        = 32,
    parameter int ADDR_REG_LENGTH       = 5,
    parameter int ADDR_MEM_DATOS_LENGTH = 10,
    parameter int CANT_MEM_DATOS_DUMP   = 16
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_start,
    input  logic [LONGITUD_DATO-1:0]         i_pc,
    input  logic [LONGITUD_DATO-1:0]         i_contador_ciclos,
    output logic [ADDR_REG_LENGTH-1:0]       o_addr_registro,
    input  logic [LONGITUD_DATO-1:0]         i_dato_registro,
    output logic [ADDR_MEM_DATOS_LENGTH-1:0] o_addr_mem_datos,
    output logic                             o_enable_mem_datos,
    input  logic [LONGITUD_DATO-1:0]         i_dato_mem_datos,
    output logic                             o_tx_start,
    output logic [OUTPUT_WORD_LENGTH-1:0]    o_data_tx,
    input  logic                             i_tx_done,
    output logic                             o_busy,
    output logic                             o_done
);

    localparam int BYTES_PER_WORD = LONGITUD_DATO / OUTPUT_WORD_LENGTH;
    localparam int BCNT_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int MEM_IDX_W      = ADDR_MEM_DATOS_LENGTH + 1;

    localparam logic [BCNT_W-1:0]          LAST_BYTE   = BCNT_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_REG_LENGTH-1:0] REG_LAST    = ADDR_REG_LENGTH'(CANT_REGISTROS - 1);
    localparam logic [MEM_IDX_W-1:0]       MEM_LAST    =
        MEM_IDX_W'((CANT_MEM_DATOS_DUMP > 0) ? CANT_MEM_DATOS_DUMP - 1 : 0);
    localparam bit                         MEM_DUMP_EN = (CANT_MEM_DATOS_DUMP > 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_TX,
        ST_READ,
        ST_WAIT_RD,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_PC,
        PH_CNT,
        PH_REG,
        PH_MEM
    } phase_t;

    state_t                          state_r, state_s;
    phase_t                          phase_r, phase_s;
    logic [BCNT_W-1:0]               byte_cnt_r, byte_cnt_s;
    logic [ADDR_REG_LENGTH-1:0]      reg_idx_r, reg_idx_s;
    logic [MEM_IDX_W-1:0]            mem_idx_r, mem_idx_s;
    logic [LONGITUD_DATO-1:0]        shift_r, shift_s;
    logic [LONGITUD_DATO-1:0]        cnt_snap_r, cnt_snap_s;
    logic                            tx_start_r, tx_start_s;
    logic [OUTPUT_WORD_LENGTH-1:0]   data_tx_r, data_tx_s;
    logic                            busy_r, busy_s;
    logic                            done_r, done_s;
    logic                            mem_en_r, mem_en_s;

    // Next-state, datapath and next-output decode for the dump sequencer.
    always_comb begin
        state_s    = state_r;
        phase_s    = phase_r;
        byte_cnt_s = byte_cnt_r;
        reg_idx_s  = reg_idx_r;
        mem_idx_s  = mem_idx_r;
        shift_s    = shift_r;
        cnt_snap_s = cnt_snap_r;
        tx_start_s = 1'b0;
        data_tx_s  = data_tx_r;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        mem_en_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    shift_s    = i_pc;
                    cnt_snap_s = i_contador_ciclos;
                    phase_s    = PH_PC;
                    byte_cnt_s = '0;
                    reg_idx_s  = '0;
                    mem_idx_s  = '0;
                    state_s    = ST_SEND;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_SEND: begin
                state_s = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (!i_tx_done) begin
                    state_s = ST_WAIT_TX;
                end else if (byte_cnt_r != LAST_BYTE) begin
                    byte_cnt_s = byte_cnt_r + BCNT_W'(1);
                    shift_s    = shift_r << OUTPUT_WORD_LENGTH;
                    state_s    = ST_SEND;
                end else begin
                    byte_cnt_s = '0;
                    case (phase_r)
                        PH_PC: begin
                            // The counter was snapshotted at start, so no read cycle is needed.
                            shift_s = cnt_snap_r;
                            phase_s = PH_CNT;
                            state_s = ST_SEND;
                        end
                        PH_CNT: begin
                            phase_s = PH_REG;
                            state_s = ST_READ;
                        end
                        PH_REG: begin
                            if (reg_idx_r != REG_LAST) begin
                                reg_idx_s = reg_idx_r + ADDR_REG_LENGTH'(1);
                                state_s   = ST_READ;
                            end else if (MEM_DUMP_EN) begin
                                phase_s   = PH_MEM;
                                state_s   = ST_READ;
                            end else begin
                                state_s   = ST_DONE;
                            end
                        end
                        PH_MEM: begin
                            if (mem_idx_r != MEM_LAST) begin
                                mem_idx_s = mem_idx_r + MEM_IDX_W'(1);
                                state_s   = ST_READ;
                            end else begin
                                state_s   = ST_DONE;
                            end
                        end
                        default: begin
                            state_s = ST_DONE;
                        end
                    endcase
                end
            end
            ST_READ: begin
                state_s = ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                state_s = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (phase_r == PH_MEM) begin
                    shift_s = i_dato_mem_datos;
                end else begin
                    shift_s = i_dato_registro;
                end
                state_s = ST_SEND;
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered without lag.
        tx_start_s = (state_s == ST_SEND);
        busy_s     = (state_s != ST_IDLE);
        done_s     = (state_s == ST_DONE);
        mem_en_s   = (state_s == ST_READ) && (phase_s == PH_MEM);
        if (state_s == ST_SEND) begin
            data_tx_s = shift_s[LONGITUD_DATO-1 -: OUTPUT_WORD_LENGTH];
        end else if (state_s == ST_IDLE) begin
            data_tx_s = '0;
        end else begin
            data_tx_s = data_tx_r;
        end
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_r    <= ST_IDLE;
            phase_r    <= PH_PC;
            byte_cnt_r <= '0;
            reg_idx_r  <= '0;
            mem_idx_r  <= '0;
            shift_r    <= '0;
            cnt_snap_r <= '0;
            tx_start_r <= 1'b0;
            data_tx_r  <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            mem_en_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            phase_r    <= phase_s;
            byte_cnt_r <= byte_cnt_s;
            reg_idx_r  <= reg_idx_s;
            mem_idx_r  <= mem_idx_s;
            shift_r    <= shift_s;
            cnt_snap_r <= cnt_snap_s;
            tx_start_r <= tx_start_s;
            data_tx_r  <= data_tx_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            mem_en_r   <= mem_en_s;
        end
    end

    assign o_addr_registro    = reg_idx_r;
    assign o_addr_mem_datos   = mem_idx_r[ADDR_MEM_DATOS_LENGTH-1:0];
    assign o_enable_mem_datos = mem_en_r;
    assign o_tx_start         = tx_start_r;
    assign o_data_tx          = data_tx_r;
    assign o_busy             = busy_r;
    assign o_done             = done_r;

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Scoreboard bench for debug_dump_sequencer: a UART/memory model answers the DUT, expected
// bytes are queued at start and popped as each o_tx_start handshake arrives.
module tb_debug_dump_sequencer;

    localparam int          N_REG   = 32;
    localparam int          N_MEM   = 16;
    localparam logic [31:0] PC_VAL  = 32'h0040_0010;
    localparam logic [31:0] CNT_VAL = 32'h0000_002A;

    logic        clk = 1'b0;
    logic        rst_n, start, tx_done_resp, tx_done_idle;
    logic [31:0] pc, ciclos, reg_data, mem_data;
    logic [4:0]  addr_reg;
    logic [9:0]  addr_mem;
    logic        mem_en, tx_start, busy, done;
    logic [7:0]  data_tx;

    logic        start0, tx_done0;
    logic [4:0]  addr_reg0;
    logic [9:0]  addr_mem0;
    logic        mem_en0, tx_start0, busy0, done0;
    logic [7:0]  data_tx0;

    logic [7:0]  exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    int          txs_cnt = 0;
    int          bytes_seen = 0;
    int          slow_left = 0;
    bit          dump_abort = 1'b0;
    int          done0_cnt = 0;
    int          bytes0 = 0;
    bit          en0_seen = 1'b0;
    logic [7:0]  last0 = 8'h00;

    always #5 clk = ~clk;

    debug_dump_sequencer dut (
        .i_clock            (clk),
        .i_reset            (rst_n),
        .i_start            (start),
        .i_pc               (pc),
        .i_contador_ciclos  (ciclos),
        .o_addr_registro    (addr_reg),
        .i_dato_registro    (reg_data),
        .o_addr_mem_datos   (addr_mem),
        .o_enable_mem_datos (mem_en),
        .i_dato_mem_datos   (mem_data),
        .o_tx_start         (tx_start),
        .o_data_tx          (data_tx),
        .i_tx_done          (tx_done_resp | tx_done_idle),
        .o_busy             (busy),
        .o_done             (done)
    );

    debug_dump_sequencer #(.CANT_MEM_DATOS_DUMP(0)) dut0 (
        .i_clock            (clk),
        .i_reset            (rst_n),
        .i_start            (start0),
        .i_pc               (pc),
        .i_contador_ciclos  (ciclos),
        .o_addr_registro    (addr_reg0),
        .i_dato_registro    ({27'd0, addr_reg0}),
        .o_addr_mem_datos   (addr_mem0),
        .o_enable_mem_datos (mem_en0),
        .i_dato_mem_datos   (32'hFFFF_FFFF),
        .o_tx_start         (tx_start0),
        .o_data_tx          (data_tx0),
        .i_tx_done          (tx_done0),
        .o_busy             (busy0),
        .o_done             (done0)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_dump(input logic [31:0] pcv, input logic [31:0] cntv);
        logic [31:0] w;
        for (int k = 0; k < 2 + N_REG + N_MEM; k++) begin
            if (k == 0)              w = pcv;
            else if (k == 1)         w = cntv;
            else if (k < 2 + N_REG)  w = 32'(k - 2);
            else                     w = 32'h100 + 32'(k - 2 - N_REG);
            for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
        end
    endtask

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (done === 1'b1)      done_cnt++;
        if (tx_start === 1'b1)  txs_cnt++;
        if (done0 === 1'b1)     done0_cnt++;
        if (mem_en0 === 1'b1)   en0_seen = 1'b1;
    end

    // Register file (reg k = k) and data memory (mem k = 0x100+k), one-cycle read latency.
    initial begin : mem_model
        logic [4:0] ra_q;
        logic [9:0] ma_q;
        logic       me_q;
        reg_data = 32'd0; mem_data = 32'd0; ra_q = 5'd0; ma_q = 10'd0; me_q = 1'b0;
        forever begin
            @(posedge clk); #1;
            reg_data = {27'd0, ra_q};
            if (me_q) mem_data = 32'h100 + {22'd0, ma_q};
            ra_q = addr_reg; ma_q = addr_mem; me_q = mem_en;
        end
    end

    // UART model for the main DUT: scoreboards each byte, checks hold, then returns tx_done.
    initial begin : uart_model
        logic [7:0] b;
        int         d;
        logic       stable, extra;
        tx_done_resp = 1'b0;
        forever begin
            if (tx_start === 1'b1) begin
                b = data_tx;
                bytes_seen++;
                if (exp_q.size() == 0) check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
                else check_eq($sformatf("byte%0d", bytes_seen), 64'(b), 64'(exp_q.pop_front()));
                d = (slow_left > 0) ? 500 : 3;
                if (slow_left > 0) slow_left--;
                stable = 1'b1; extra = 1'b0;
                for (int i = 1; i < d; i++) begin
                    @(posedge clk); #1;
                    if (data_tx !== b) stable = 1'b0;
                    if (tx_start === 1'b1) extra = 1'b1;
                end
                if (!dump_abort) check_eq("tx_hold", {62'd0, extra, stable}, 64'd1);
                tx_done_resp = 1'b1;
                @(posedge clk); #1;
                tx_done_resp = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    // UART model for the register-only instance.
    initial begin : uart_model0
        tx_done0 = 1'b0;
        forever begin
            if (tx_start0 === 1'b1) begin
                last0 = data_tx0;
                bytes0++;
                repeat (3) @(posedge clk);
                #1 tx_done0 = 1'b1;
                @(posedge clk); #1;
                tx_done0 = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    task automatic run_dump(input string tag, input int inject_at);
        int d0, t0, b0;
        bit got, injected;
        pc = PC_VAL; ciclos = CNT_VAL;
        dump_abort = 1'b0;
        push_dump(PC_VAL, CNT_VAL);
        d0 = done_cnt; t0 = txs_cnt; b0 = bytes_seen;
        got = 1'b0; injected = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check_eq($sformatf("%s_first_start", tag), 64'(tx_start), 64'd1);
        check_eq($sformatf("%s_busy", tag), 64'(busy), 64'd1);
        pc = 32'hDEAD_BEEF; ciclos = 32'hFFFF_0000;
        for (int i = 0; i < 20000 && !got; i++) begin
            @(posedge clk); #1;
            if (start) start = 1'b0;
            else if (!injected && inject_at >= 0 && (bytes_seen - b0) >= inject_at) begin
                start = 1'b1; injected = 1'b1;
            end
            if (done_cnt != d0) got = 1'b1;
        end
        start = 1'b0;
        check_eq($sformatf("%s_done_seen", tag), 64'(got), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        check_eq($sformatf("%s_done_pulses", tag), 64'(done_cnt - d0), 64'd1);
        check_eq($sformatf("%s_tx_pulses", tag), 64'(txs_cnt - t0), 64'd200);
        check_eq($sformatf("%s_bytes", tag), 64'(bytes_seen - b0), 64'd200);
        check_eq($sformatf("%s_queue_left", tag), 64'(exp_q.size()), 64'd0);
        check_eq($sformatf("%s_idle_busy", tag), 64'(busy), 64'd0);
    endtask

    initial begin : main
        int  d0, t0, b0;
        bit  got;
        rst_n = 1'b0; start = 1'b0; tx_done_idle = 1'b0; start0 = 1'b0;
        pc = PC_VAL; ciclos = CNT_VAL;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", 64'({tx_start, busy, done, mem_en, data_tx, addr_reg, addr_mem}), 64'd0);
        rst_n = 1'b1;

        // tx_done pulses while idle must not provoke any output activity.
        t0 = txs_cnt;
        repeat (4) begin
            tx_done_idle = 1'b1; @(posedge clk); #1;
            tx_done_idle = 1'b0; @(posedge clk); #1;
        end
        check_eq("idle_no_tx", 64'(txs_cnt - t0), 64'd0);
        check_eq("idle_not_busy", 64'(busy), 64'd0);

        run_dump("base", -1);
        slow_left = 3;
        run_dump("slow", -1);
        run_dump("restart_req", 50);

        // Reset for one cycle at byte 20 aborts the dump.
        dump_abort = 1'b0;
        pc = PC_VAL; ciclos = CNT_VAL;
        push_dump(PC_VAL, CNT_VAL);
        b0 = bytes_seen; got = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(posedge clk); #1;
            if ((bytes_seen - b0) >= 20) got = 1'b1;
        end
        check_eq("abort_reached_byte20", 64'(got), 64'd1);
        dump_abort = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("abort_outputs", 64'({tx_start, busy, data_tx}), 64'd0);
        exp_q.delete();
        d0 = done_cnt; t0 = txs_cnt;
        repeat (40) @(posedge clk);
        #1;
        check_eq("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check_eq("abort_no_tx", 64'(txs_cnt - t0), 64'd0);
        run_dump("after_abort", -1);

        // Register-only instance: no memory phase.
        b0 = bytes0; d0 = done0_cnt; got = 1'b0;
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        for (int i = 0; i < 20000 && !got; i++) begin
            @(posedge clk); #1;
            if (done0_cnt != d0) got = 1'b1;
        end
        check_eq("nomem_done_seen", 64'(got), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        check_eq("nomem_bytes", 64'(bytes0 - b0), 64'd136);
        check_eq("nomem_last_byte", 64'(last0), 64'h1F);
        check_eq("nomem_enable_never", 64'(en0_seen), 64'd0);
        check_eq("nomem_done_pulses", 64'(done0_cnt - d0), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
